// File: rtl/buzzer_note_fetch.sv
// Background-music engine: fetches 32-bit note words from memory and plays each one as a
// square wave on the buzzer pin, signalling end-of-song with a one-cycle Bref pulse.
module buzzer_note_fetch #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] BRstAddr,
    input  logic        BisPlaying,
    input  logic        Bstop,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemAck,
    input  logic [31:0] MemData,
    output logic        Bref,
    output logic        Buzzer
);

    localparam int unsigned AW = 32;
    localparam int unsigned HW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned PW = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hp_q, hp_d;
    logic [DW-1:0] dur_q, dur_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          level_q, level_d;
    logic          buzzer_d;
    logic          mem_req_d;
    logic [AW-1:0] mem_addr_d;
    logic          bref_d;
    logic          tick;

    // State and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            hp_q    <= '0;
            dur_q   <= '0;
            presc_q <= '0;
            hcnt_q  <= '0;
            level_q <= 1'b0;
            Buzzer  <= 1'b0;
            MemReq  <= 1'b0;
            MemAddr <= '0;
            Bref    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hp_q    <= hp_d;
            dur_q   <= dur_d;
            presc_q <= presc_d;
            hcnt_q  <= hcnt_d;
            level_q <= level_d;
            Buzzer  <= buzzer_d;
            MemReq  <= mem_req_d;
            MemAddr <= mem_addr_d;
            Bref    <= bref_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hp_d       = hp_q;
        dur_d      = dur_q;
        presc_d    = presc_q;
        hcnt_d     = hcnt_q;
        level_d    = level_q;
        buzzer_d   = 1'b0;
        mem_req_d  = MemReq;
        mem_addr_d = MemAddr;
        bref_d     = 1'b0;
        tick       = (presc_q == PW'(TICK_DIV - 1));

        case (state_q)
            S_IDLE: begin
                if (BisPlaying && !Bstop) begin
                    ptr_d      = BRstAddr;
                    mem_req_d  = 1'b1;
                    mem_addr_d = BRstAddr;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                // The ack is always awaited; playback enable is only judged when it lands
                if (MemAck) begin
                    mem_req_d = 1'b0;
                    if (!BisPlaying) begin
                        state_d = S_IDLE;
                    end else if (MemData == 32'd0) begin
                        bref_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        hp_d    = MemData[31:16];
                        dur_d   = MemData[15:0];
                        presc_d = '0;
                        hcnt_d  = '0;
                        level_d = 1'b0;
                        state_d = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                if (!BisPlaying) begin
                    state_d = S_IDLE;
                end else if (!Bstop) begin
                    if ((dur_q == DW'(0)) || (tick && (dur_q == DW'(1)))) begin
                        ptr_d      = ptr_q + 32'd4;
                        mem_req_d  = 1'b1;
                        mem_addr_d = ptr_q + 32'd4;
                        dur_d      = '0;
                        level_d    = 1'b0;
                        state_d    = S_FETCH;
                    end else begin
                        presc_d = tick ? '0 : presc_q + PW'(1);
                        if (tick) begin
                            dur_d = dur_q - DW'(1);
                        end
                        if (hp_q != HW'(0)) begin
                            if (hcnt_q == hp_q - HW'(1)) begin
                                hcnt_d  = '0;
                                level_d = ~level_q;
                            end else begin
                                hcnt_d = hcnt_q + HW'(1);
                            end
                        end
                        buzzer_d = level_d;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_buzzer_note_fetch.sv
// Bench for buzzer_note_fetch: note-level timing model checked every cycle, memory and
// register-block responders, and directed song scenarios with literal timing checks.
module tb_buzzer_note_fetch;

    localparam int unsigned TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] BRstAddr = 32'h100;
    logic        BisPlaying = 1'b0;
    logic        Bstop = 1'b0;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck = 1'b0;
    logic [31:0] MemData = 32'h0;
    logic        Bref;
    logic        Buzzer;

    buzzer_note_fetch #(.TICK_DIV(TICK_DIV)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .BRstAddr(BRstAddr),
        .BisPlaying(BisPlaying),
        .Bstop(Bstop),
        .MemReq(MemReq),
        .MemAddr(MemAddr),
        .MemAck(MemAck),
        .MemData(MemData),
        .Bref(Bref),
        .Buzzer(Buzzer)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [31:0] mem [0:63];
    int ack_lat = 1;
    int cyc_left = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        if (addr >= 32'h100 && addr < 32'h200) return mem[(addr - 32'h100) >> 2];
        return 32'h0;
    endfunction

    // Memory with fixed ack latency, and register block clearing BisPlaying on Bref
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            MemAck  = 1'b0;
            MemData = 32'h0;
            if (MemReq === 1'b1 && rst_n) begin
                wait_cnt++;
                if (wait_cnt >= ack_lat) begin
                    MemAck   = 1'b1;
                    MemData  = mem_rd(MemAddr);
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
            if (Bref === 1'b1) begin
                if (cyc_left > 0) cyc_left--;
                else BisPlaying = 1'b0;
            end
        end
    end

    // Note-level model: a note lasts DUR*TICK_DIV active cycles (1 if DUR==0); after k
    // active cycles the wave level is floor(k/HP) mod 2
    int          m_phase = 0;  // 0 idle, 1 fetch, 2 play, 3 done
    logic [31:0] m_ptr = 32'h0;
    int          m_hp = 0;
    int          m_dur = 0;
    int          m_active = 0;
    logic        e_req = 1'b0;
    logic [31:0] e_addr = 32'h0;
    logic        e_bref = 1'b0;
    logic        e_buz = 1'b0;

    int   cyc = 0;
    int   rise_q[$];
    int   bref_q[$];
    int   hi_cnt = 0;
    logic prev_req = 1'b0;

    function automatic int note_len(input int dur);
        return (dur == 0) ? 1 : dur * int'(TICK_DIV);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_phase = 0; m_ptr = 32'h0;
                e_req = 1'b0; e_addr = 32'h0; e_bref = 1'b0; e_buz = 1'b0;
            end else begin
                case (m_phase)
                    0: begin
                        e_buz = 1'b0;
                        if (BisPlaying && !Bstop) begin
                            m_ptr = BRstAddr; e_req = 1'b1; e_addr = BRstAddr; m_phase = 1;
                        end
                    end
                    1: if (MemAck) begin
                        e_req = 1'b0;
                        if (!BisPlaying) m_phase = 0;
                        else if (MemData == 32'h0) begin e_bref = 1'b1; m_phase = 3; end
                        else begin
                            m_hp = int'(MemData[31:16]); m_dur = int'(MemData[15:0]);
                            m_active = 0; e_buz = 1'b0; m_phase = 2;
                        end
                    end
                    2: begin
                        if (!BisPlaying) begin e_buz = 1'b0; m_phase = 0; end
                        else if (Bstop) e_buz = 1'b0;
                        else begin
                            m_active++;
                            if (m_active >= note_len(m_dur)) begin
                                m_ptr = m_ptr + 32'd4; e_req = 1'b1; e_addr = m_ptr;
                                e_buz = 1'b0; m_phase = 1;
                            end else begin
                                e_buz = (m_hp != 0) && (((m_active / m_hp) % 2) == 1);
                            end
                        end
                    end
                    default: begin e_bref = 1'b0; m_phase = 0; end
                endcase
            end
            @(negedge clk);
            cyc++;
            check("MemReq", 32'(MemReq), 32'(e_req));
            check("MemAddr", MemAddr, e_addr);
            check("Bref", 32'(Bref), 32'(e_bref));
            check("Buzzer", 32'(Buzzer), 32'(e_buz));
            if (MemReq === 1'b1 && !prev_req) rise_q.push_back(cyc);
            prev_req = (MemReq === 1'b1);
            if (Bref === 1'b1) bref_q.push_back(cyc);
            if (Buzzer === 1'b1) hi_cnt++;
        end
    end

    int r0, b0, h0;

    task automatic snap();
        r0 = rise_q.size(); b0 = bref_q.size(); h0 = hi_cnt;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!(BisPlaying == 1'b0 && m_phase == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("run_bound", 32'(n < budget), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_song(input string tag, input int rises, input int gap,
                              input int brefs, input int highs);
        check({tag, "_rises"}, 32'(rise_q.size() - r0), 32'(rises));
        if (rises >= 2) check({tag, "_gap"}, 32'(rise_q[r0+1] - rise_q[r0]), 32'(gap));
        check({tag, "_bref"}, 32'(bref_q.size() - b0), 32'(brefs));
        check({tag, "_high"}, 32'(hi_cnt - h0), 32'(highs));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h0003_0002;
        #1 rst_n = 1'b0;
        #1;
        check("rst_req", 32'(MemReq), 32'd0);
        check("rst_addr", MemAddr, 32'd0);
        check("rst_bref", 32'(Bref), 32'd0);
        check("rst_buz", 32'(Buzzer), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1: single note then end marker
        snap(); BisPlaying = 1'b1;
        wait_done(100);
        check_song("t1", 2, 9, 1, 3);
        check("t1_bref_lat", 32'(bref_q[b0] - rise_q[r0+1]), 32'd1);

        // T2: cyclic, two passes
        cyc_left = 1; snap(); BisPlaying = 1'b1;
        wait_done(200);
        check_song("t2", 4, 9, 2, 6);
        check("t2_restart", 32'(rise_q[r0+2] - bref_q[b0]), 32'd2);

        // T3: 10-cycle pause mid-note while the wave is high
        snap(); BisPlaying = 1'b1;
        repeat (6) @(negedge clk);
        Bstop = 1'b1;
        repeat (10) @(negedge clk);
        Bstop = 1'b0;
        wait_done(200);
        check_song("t3", 2, 19, 1, 3);

        // T4: playback disabled mid-note
        snap(); BisPlaying = 1'b1;
        repeat (5) @(negedge clk);
        BisPlaying = 1'b0;
        repeat (20) @(negedge clk);
        check_song("t4", 1, 0, 0, 1);

        // T5: rest note of one tick
        mem[0] = 32'h0000_0001;
        snap(); BisPlaying = 1'b1;
        wait_done(100);
        check_song("t5", 2, 5, 1, 0);
        mem[0] = 32'h0003_0002;

        // T6: slow memory, reset pulsed mid-fetch
        ack_lat = 5;
        snap(); BisPlaying = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_arst_req", 32'(MemReq), 32'd0);
        check("t6_arst_addr", MemAddr, 32'd0);
        check("t6_arst_bref", 32'(Bref), 32'd0);
        check("t6_arst_buz", 32'(Buzzer), 32'd0);
        BisPlaying = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_song("t6_rst", 1, 0, 0, 0);
        snap(); BisPlaying = 1'b1;
        wait_done(200);
        check_song("t6", 2, 13, 1, 3);

        // T7: enable dropped while the slow fetch is outstanding
        snap(); BisPlaying = 1'b1;
        repeat (2) @(negedge clk);
        BisPlaying = 1'b0;
        repeat (15) @(negedge clk);
        check_song("t7", 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
